// File: rtl/dct8x8_zigzag_if.sv
// Handshake bundle between the DCT core, the zigzag reorder stage and the quantiser.
interface dct8x8_zigzag_if #(parameter int COEF_W = 16);
    logic                  zz_vld_i;
    logic [16*COEF_W-1:0]  zz_data_i;
    logic                  zz_rdy_i;
    logic                  zz_vld_o;
    logic [16*COEF_W-1:0]  zz_data_o;
    logic                  zz_last_o;
    logic                  zz_rdy_o;

    modport master (
        output zz_vld_i, zz_data_i, zz_rdy_o,
        input  zz_rdy_i, zz_vld_o, zz_data_o, zz_last_o
    );
    modport slave (
        input  zz_vld_i, zz_data_i, zz_rdy_o,
        output zz_rdy_i, zz_vld_o, zz_data_o, zz_last_o
    );
endinterface

// File: rtl/dct8x8_zigzag.sv
// Raster-to-zigzag reorder of 8x8 coefficient blocks, 16 coefs per beat,
// ping-pong buffered so one bank fills while the other drains.

module dct8x8_zz_lane #(
    parameter int COEF_W = 16,
    parameter int LANE   = 0
) (
    input  logic [63:0][COEF_W-1:0] blk,
    input  logic [1:0]              beat,
    output logic [COEF_W-1:0]       coef
);
    localparam logic [3:0] L = 4'(LANE);
    localparam int ZZ [64] = '{
         0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
        12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
        35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
        58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

    logic [5:0] src;
    assign src  = 6'(ZZ[{beat, L}]);
    assign coef = blk[src];
endmodule

module dct8x8_zigzag #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_W     = DATA_WIDTH + 8
) (
    input logic          clk,
    input logic          rst,
    dct8x8_zigzag_if.slave zz
);
    logic [1:0][3:0][15:0][COEF_W-1:0] bank;
    logic [1:0]                        full;
    logic                              wr_bank, rd_bank;
    logic [1:0]                        wr_beat, rd_beat;
    logic                              in_fire, out_fire;
    logic [63:0][COEF_W-1:0]           rd_blk;
    logic [15:0][COEF_W-1:0]           gather;

    assign zz.zz_rdy_i  = ~full[wr_bank];
    assign zz.zz_vld_o  = full[rd_bank];
    assign zz.zz_last_o = full[rd_bank] & (rd_beat == 2'd3);
    assign in_fire      = zz.zz_vld_i & ~full[wr_bank];
    assign out_fire     = full[rd_bank] & zz.zz_rdy_o;

    // Raster order within a bank: beat-major, lane-minor, so the flat view is r = row*8+col.
    assign rd_blk = bank[rd_bank];

    for (genvar j = 0; j < 16; j++) begin : g_lane
        dct8x8_zz_lane #(.COEF_W(COEF_W), .LANE(j)) u_lane (
            .blk  (rd_blk),
            .beat (rd_beat),
            .coef (gather[j])
        );
    end
    assign zz.zz_data_o = gather;

    // Final write and final read always target different banks, so both may update full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank    <= '0;
            full    <= '0;
            wr_bank <= 1'b0;
            wr_beat <= 2'd0;
            rd_bank <= 1'b0;
            rd_beat <= 2'd0;
        end else begin
            if (in_fire) begin
                bank[wr_bank][wr_beat] <= zz.zz_data_i;
                wr_beat                <= wr_beat + 2'd1;
                if (wr_beat == 2'd3) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (out_fire) begin
                rd_beat <= rd_beat + 2'd1;
                if (rd_beat == 2'd3) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_dct8x8_zigzag.sv
// Directed and randomised checks of the zigzag reorder stage against a table model.
module tb_dct8x8_zigzag;
    localparam int CW = 16;
    localparam int BW = 16 * CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dct8x8_zigzag_if #(.COEF_W(CW)) zif ();
    dct8x8_zigzag #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .zz(zif.slave));

    int ZZ [64] = '{
         0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
        12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
        35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
        58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

    typedef logic [63:0][CW-1:0] blk_t;

    blk_t b0, b1, b2, cur;
    logic [15:0][15:0] t1b0 = '{16'd5, 16'd4, 16'd11, 16'd18, 16'd25, 16'd32, 16'd24, 16'd17,
                                16'd10, 16'd3, 16'd2, 16'd9, 16'd16, 16'd8, 16'd1, 16'd0};
    logic [BW-1:0] q [$];
    logic [BW-1:0] d;
    logic v, r, in_acc;
    int in_blk, in_beat, out_cnt, cyc;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic blk_t ramp(input int off);
        blk_t b;
        for (int i = 0; i < 64; i++) b[i] = CW'(i + off);
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 64; i++) b[i] = CW'($urandom);
        return b;
    endfunction

    function automatic logic [BW-1:0] in_beat_of(input blk_t b, input int k);
        return b[k*16 +: 16];
    endfunction

    function automatic logic [BW-1:0] zz_beat(input blk_t b, input int k);
        logic [15:0][CW-1:0] o;
        for (int j = 0; j < 16; j++) o[j] = b[ZZ[k*16 + j]];
        return o;
    endfunction

    // Inputs are applied on the falling edge; outputs are checked before this is called.
    task automatic step(input logic vi, input logic [BW-1:0] di, input logic ro);
        zif.zz_vld_i  = vi;
        zif.zz_data_i = di;
        zif.zz_rdy_o  = ro;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        zif.zz_vld_i = 1'b0;
        zif.zz_rdy_o = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        zif.zz_vld_i  = 1'b0;
        zif.zz_data_i = '0;
        zif.zz_rdy_o  = 1'b0;
        do_reset();
        chk("rst_vld",  zif.zz_vld_o,  0);
        chk("rst_rdy",  zif.zz_rdy_i,  1);
        chk("rst_data", zif.zz_data_o, 0);
        chk("rst_last", zif.zz_last_o, 0);

        // T1 ramp block, single pass
        b0 = ramp(0);
        for (int k = 0; k < 4; k++) begin
            chk("t1_vld_early", zif.zz_vld_o, 0);
            step(1'b1, in_beat_of(b0, k), 1'b1);
        end
        chk("t1_vld_rise", zif.zz_vld_o, 1);
        chk("t1_beat0_hand", zif.zz_data_o, BW'(t1b0));
        for (int k = 0; k < 4; k++) begin
            chk("t1_vld",  zif.zz_vld_o, 1);
            chk("t1_data", zif.zz_data_o, zz_beat(b0, k));
            chk("t1_last", zif.zz_last_o, BW'(k == 3));
            if (k == 3) chk("t1_lane15", BW'(zif.zz_data_o[BW-1 -: CW]), 63);
            step(1'b0, '0, 1'b1);
        end
        chk("t1_vld_fall", zif.zz_vld_o, 0);

        // T2 three back-to-back blocks at full rate
        do_reset();
        for (int t = 0; t < 17; t++) begin
            if (t >= 4 && t < 16) begin
                chk("t2_vld",  zif.zz_vld_o, 1);
                chk("t2_data", zif.zz_data_o, zz_beat(ramp(100 * ((t - 4) / 4)), (t - 4) % 4));
            end
            if (t < 12) begin
                chk("t2_rdy", zif.zz_rdy_i, 1);
                step(1'b1, in_beat_of(ramp(100 * (t / 4)), t % 4), 1'b1);
            end else begin
                step(1'b0, '0, 1'b1);
            end
        end
        chk("t2_idle", zif.zz_vld_o, 0);

        // T3 backpressure with both banks full
        do_reset();
        b0 = ramp(1000);
        b1 = ramp(2000);
        b2 = ramp(3000);
        for (int k = 0; k < 8; k++)
            step(1'b1, in_beat_of(k < 4 ? b0 : b1, k % 4), 1'b0);
        chk("t3_rdy_low", zif.zz_rdy_i, 0);
        for (int c = 0; c < 3; c++) begin
            chk("t3_hold_rdy",  zif.zz_rdy_i, 0);
            chk("t3_hold_vld",  zif.zz_vld_o, 1);
            chk("t3_hold_data", zif.zz_data_o, zz_beat(b0, 0));
            chk("t3_hold_last", zif.zz_last_o, 0);
            step(1'b1, in_beat_of(b2, 0), 1'b0);
        end
        for (int c = 0; c < 4; c++) begin
            chk("t3_drain0_rdy",  zif.zz_rdy_i, 0);
            chk("t3_drain0_data", zif.zz_data_o, zz_beat(b0, c));
            chk("t3_drain0_last", zif.zz_last_o, BW'(c == 3));
            step(1'b1, in_beat_of(b2, 0), 1'b1);
        end
        chk("t3_rdy_rise", zif.zz_rdy_i, 1);
        for (int c = 0; c < 4; c++) begin
            chk("t3_drain1_vld",  zif.zz_vld_o, 1);
            chk("t3_drain1_data", zif.zz_data_o, zz_beat(b1, c));
            step(c == 0, in_beat_of(b2, 0), 1'b1);
        end
        chk("t3_partial_idle", zif.zz_vld_o, 0);

        // T4 extreme signed values
        do_reset();
        for (int i = 0; i < 64; i++) b0[i] = (i % 2 == 1) ? 16'h7FFF : 16'h8000;
        for (int k = 0; k < 4; k++) step(1'b1, in_beat_of(b0, k), 1'b1);
        chk("t4_lane0_neg", BW'(zif.zz_data_o[15:0]),  16'h8000);
        chk("t4_lane1_pos", BW'(zif.zz_data_o[31:16]), 16'h7FFF);
        for (int k = 0; k < 4; k++) begin
            chk("t4_data", zif.zz_data_o, zz_beat(b0, k));
            step(1'b0, '0, 1'b1);
        end

        // T5 reset mid-block
        do_reset();
        b0 = ramp(500);
        step(1'b1, in_beat_of(b0, 0), 1'b1);
        step(1'b1, in_beat_of(b0, 1), 1'b1);
        zif.zz_vld_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_vld",  zif.zz_vld_o,  0);
        chk("t5_rdy",  zif.zz_rdy_i,  1);
        chk("t5_data", zif.zz_data_o, 0);
        @(negedge clk);
        rst = 1'b0;
        b1 = ramp(7);
        for (int k = 0; k < 4; k++) begin
            chk("t5_no_early", zif.zz_vld_o, 0);
            step(1'b1, in_beat_of(b1, k), 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            chk("t5_vld2", zif.zz_vld_o, 1);
            chk("t5_data2", zif.zz_data_o, zz_beat(b1, k));
            step(1'b0, '0, 1'b1);
        end

        // T6 random gaps on both sides, 100 blocks
        do_reset();
        in_blk = 0; in_beat = 0; out_cnt = 0; cyc = 0;
        cur = rand_blk();
        for (int k = 0; k < 4; k++) q.push_back(zz_beat(cur, k));
        while (out_cnt < 400 && cyc < 20000) begin
            v = (in_blk < 100) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            if (zif.zz_vld_o && r) begin
                if (q.size() == 0) begin
                    chk("t6_spurious", zif.zz_vld_o, 0);
                end else begin
                    chk("t6_data", zif.zz_data_o, q[0]);
                    chk("t6_last", zif.zz_last_o, BW'(out_cnt % 4 == 3));
                    void'(q.pop_front());
                end
                out_cnt++;
            end
            in_acc = v && zif.zz_rdy_i;
            d = in_beat_of(cur, in_beat);
            step(v, d, r);
            if (in_acc) begin
                in_beat++;
                if (in_beat == 4) begin
                    in_beat = 0;
                    in_blk++;
                    if (in_blk < 100) begin
                        cur = rand_blk();
                        for (int k = 0; k < 4; k++) q.push_back(zz_beat(cur, k));
                    end
                end
            end
            cyc++;
        end
        chk("t6_out_count", BW'(out_cnt), 400);
        chk("t6_in_count",  BW'(in_blk),  100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
